lifo_mc: RTL and testbench
==========================

# lifo_mc

Multi-channel LIFO: CH_NUM independent stacks sharing one inferred RAM, each stack 2**AWIDTH words deep, with per-channel status flags and fill counts. It generalises the single-channel LIFO to several channels and adds same-cycle swap, per-channel clear and overflow/underflow reporting. It sits between packet producers that push per-context state and consumers that pop the most recent entry per context.

## Interface
- DWIDTH, 16, data word width
- AWIDTH, 8, per-channel address width; depth DEPTH = 2**AWIDTH
- CH_NUM, 4, number of channels (>= 2)
- ALMOST_FULL, 14, almost_full threshold (usedw >= ALMOST_FULL)
- ALMOST_EMPTY, 2, almost_empty threshold (usedw <= ALMOST_EMPTY)
- CHWIDTH, $clog2(CH_NUM), derived, not overridden
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- clr_i  in  CH_NUM  per-channel synchronous clear
- wrreq_i  in  1  push request
- wrch_i  in  CHWIDTH  push channel
- data_i  in  DWIDTH  push data
- rdreq_i  in  1  pop request
- rdch_i  in  CHWIDTH  pop channel
- q_o  out  DWIDTH  popped data
- q_valid_o  out  1  q_o valid strobe
- q_ch_o  out  CHWIDTH  channel of q_o
- empty_o, almost_empty_o, full_o, almost_full_o  out  CH_NUM each  per-channel flags
- usedw_o  out  CH_NUM*(AWIDTH+1)  per-channel fill count, channel c at bits [c*(AWIDTH+1) +: AWIDTH+1]
- ovf_o  out  1  push to full channel dropped
- udf_o  out  1  pop from empty channel dropped

## Operation
- Channel c occupies RAM words c*DEPTH .. c*DEPTH+DEPTH-1; usedw[c] is its stack pointer (0..DEPTH).
- Push (wrreq_i, channel w not full): mem[w*DEPTH + usedw[w]] <= data_i; usedw[w]++.
- Pop (rdreq_i, channel r not empty): read mem[r*DEPTH + usedw[r]-1]; usedw[r]--.
- Push and pop on different channels in the same cycle: both execute independently.
- Push and pop on same channel, channel non-empty (including full): swap — q_o returns old top, data_i overwrites that word, usedw unchanged (read-first RAM), no ovf.
- Same channel, channel empty: push executes, pop dropped, udf_o pulses.
- Push to full channel (no same-channel pop): dropped, memory and usedw unchanged, ovf_o pulses.
- Pop from empty channel: dropped, q_valid_o stays 0, udf_o pulses.
- clr_i[c]: usedw[c] <= 0 next cycle; overrides push/pop to c that cycle (no ovf/udf, no q_valid_o for c). Other channels unaffected.
- Flags per channel: empty = usedw==0, full = usedw==DEPTH, almost_full = usedw>=ALMOST_FULL, almost_empty = usedw<=ALMOST_EMPTY; decoded from registered usedw.
- RAM contents are not reset or cleared.

## Timing
- Reset (arst_i high, asynchronous): usedw_o all 0, empty_o all 1, almost_empty_o all 1, full_o 0, almost_full_o 0, q_o 0, q_valid_o 0, q_ch_o 0, ovf_o 0, udf_o 0.
- Request sampled at rising edge N; usedw_o and flags reflect it after edge N.
- Pop latency 1: q_o, q_ch_o, q_valid_o valid after edge N+1... precisely: registered at edge N+1 from request sampled at edge N, q_valid_o high one cycle per accepted pop; q_o holds last value otherwise.
- ovf_o/udf_o: single-cycle registered pulses, same cycle as q_valid_o would be.
- Back-to-back pops on one channel every cycle supported, returning strict LIFO order.
- Reset asserted mid-operation: all state above returns to reset values immediately; a pending pop yields no q_valid_o.

## Structure
- Package lifo_mc_pkg: flag-bundle typedef (empty, almost_empty, full, almost_full) and function for usedw slice offset.
- Sub-module lifo_mc_ptr: one channel's pointer, flags, accept/drop decision; generated CH_NUM times. RAM and output register in top.

## Test plan
- Reset, then 257 pushes ch0 with DWIDTH=16, AWIDTH=8 -> usedw0=256, full_o[0]=1, one ovf_o pulse, other channels empty.
- 257 pops ch0 -> 256 q_valid_o strobes, data reversed of pushes, one udf_o, empty_o[0]=1.
- Interleave pushes ch1/ch2 alternating, then pop each -> per-channel LIFO order, no cross-channel corruption.
- Push 3 words ch3, then push 0xBEEF + pop ch3 same cycle -> q_o = third word, usedw3 stays 3, next pop returns 0xBEEF.
- Fill ch0 to 5, clr_i[0] with pop ch0 same cycle -> usedw0=0, no q_valid_o, no udf_o.
- Assert arst_i between clock edges during pop burst -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/lifo_mc_pkg.sv
// lifo_mc_pkg: shared types and helpers for the multi-channel LIFO.
//   flags_t   - per-channel status flag bundle
//   usedw_off - bit offset of a channel's fill count inside the packed usedw bus
package lifo_mc_pkg;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic full;
        logic almost_full;
    } flags_t;

    function automatic int unsigned usedw_off(input int unsigned ch, input int unsigned awidth);
        return ch * (awidth + 1);
    endfunction

endpackage

// File: rtl/lifo_mc_ptr.sv
// lifo_mc_ptr: stack pointer, status flags and accept/drop decision for one channel.
//   clk_i, arst_i   clock, asynchronous active-high reset
//   clr_i           synchronous clear of this channel (wins over push/pop)
//   wr_i, rd_i      push / pop addressed to this channel
//   usedw_o         fill count (0..2**AWIDTH)
//   flags_o         empty / almost_empty / full / almost_full, decoded from usedw
//   we_o, waddr_o   RAM write enable and in-channel write address
//   re_o, raddr_o   RAM read enable and in-channel read address
//   ovf_o, udf_o    push dropped (full) / pop dropped (empty), combinational
module lifo_mc_ptr
    import lifo_mc_pkg::*;
#(
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 14,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic              rd_i,
    output logic [AWIDTH:0]   usedw_o,
    output flags_t            flags_o,
    output logic              we_o,
    output logic [AWIDTH-1:0] waddr_o,
    output logic              re_o,
    output logic [AWIDTH-1:0] raddr_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam logic [AWIDTH:0] DEPTH_W = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AF_W    = ALMOST_FULL[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_W    = ALMOST_EMPTY[AWIDTH:0];

    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic [AWIDTH-1:0] top_w;
    logic              empty_w, full_w;

    assign empty_w = (usedw_q == '0);
    assign full_w  = (usedw_q == DEPTH_W);
    // Word holding the current top; wraps to DEPTH-1 when the stack is full.
    assign top_w   = usedw_q[AWIDTH-1:0] - AWIDTH'(1);

    always_comb begin
        flags_o.empty        = empty_w;
        flags_o.almost_empty = (usedw_q <= AE_W);
        flags_o.full         = full_w;
        flags_o.almost_full  = (usedw_q >= AF_W);
    end

    always_comb begin
        usedw_d = usedw_q;
        we_o    = 1'b0;
        re_o    = 1'b0;
        ovf_o   = 1'b0;
        udf_o   = 1'b0;
        waddr_o = usedw_q[AWIDTH-1:0];
        raddr_o = top_w;
        if (clr_i) begin
            usedw_d = '0;
        end else if (wr_i && rd_i) begin
            if (empty_w) begin
                we_o    = 1'b1;
                udf_o   = 1'b1;
                usedw_d = usedw_q + 1'b1;
            end else begin
                // Swap: read the old top and overwrite it in the same RAM cycle.
                we_o    = 1'b1;
                re_o    = 1'b1;
                waddr_o = top_w;
            end
        end else if (wr_i) begin
            if (full_w) begin
                ovf_o = 1'b1;
            end else begin
                we_o    = 1'b1;
                usedw_d = usedw_q + 1'b1;
            end
        end else if (rd_i) begin
            if (empty_w) begin
                udf_o = 1'b1;
            end else begin
                re_o    = 1'b1;
                usedw_d = usedw_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) usedw_q <= '0;
        else        usedw_q <= usedw_d;
    end

    assign usedw_o = usedw_q;

endmodule

// File: rtl/lifo_mc.sv
// lifo_mc: CH_NUM independent LIFO stacks sharing one RAM.
//   clk_i, arst_i            clock, asynchronous active-high reset
//   clr_i[c]                 synchronous clear of channel c
//   wrreq_i, wrch_i, data_i  push request
//   rdreq_i, rdch_i          pop request
//   q_o, q_valid_o, q_ch_o   popped word, strobe and channel (two edges after request)
//   empty_o .. almost_full_o per-channel flags
//   usedw_o                  per-channel fill counts, packed (AWIDTH+1) bits each
//   ovf_o, udf_o             dropped push / dropped pop pulses, aligned with q_valid_o
module lifo_mc
    import lifo_mc_pkg::*;
#(
    parameter  int DWIDTH       = 16,
    parameter  int AWIDTH       = 8,
    parameter  int CH_NUM       = 4,
    parameter  int ALMOST_FULL  = 14,
    parameter  int ALMOST_EMPTY = 2,
    localparam int CHWIDTH      = $clog2(CH_NUM)
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [CH_NUM-1:0]            clr_i,
    input  logic                         wrreq_i,
    input  logic [CHWIDTH-1:0]           wrch_i,
    input  logic [DWIDTH-1:0]            data_i,
    input  logic                         rdreq_i,
    input  logic [CHWIDTH-1:0]           rdch_i,
    output logic [DWIDTH-1:0]            q_o,
    output logic                         q_valid_o,
    output logic [CHWIDTH-1:0]           q_ch_o,
    output logic [CH_NUM-1:0]            empty_o,
    output logic [CH_NUM-1:0]            almost_empty_o,
    output logic [CH_NUM-1:0]            full_o,
    output logic [CH_NUM-1:0]            almost_full_o,
    output logic [CH_NUM*(AWIDTH+1)-1:0] usedw_o,
    output logic                         ovf_o,
    output logic                         udf_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int RAW   = CHWIDTH + AWIDTH;

    logic [CH_NUM-1:0] we_c, re_c, ovf_c, udf_c;
    logic [AWIDTH-1:0] waddr_c [CH_NUM];
    logic [AWIDTH-1:0] raddr_c [CH_NUM];
    logic [AWIDTH:0]   usedw_c [CH_NUM];
    flags_t            flags_c [CH_NUM];

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        lifo_mc_ptr #(
            .AWIDTH      (AWIDTH),
            .ALMOST_FULL (ALMOST_FULL),
            .ALMOST_EMPTY(ALMOST_EMPTY)
        ) u_ptr (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .clr_i  (clr_i[c]),
            .wr_i   (wrreq_i && (wrch_i == CHWIDTH'(c))),
            .rd_i   (rdreq_i && (rdch_i == CHWIDTH'(c))),
            .usedw_o(usedw_c[c]),
            .flags_o(flags_c[c]),
            .we_o   (we_c[c]),
            .waddr_o(waddr_c[c]),
            .re_o   (re_c[c]),
            .raddr_o(raddr_c[c]),
            .ovf_o  (ovf_c[c]),
            .udf_o  (udf_c[c])
        );

        assign usedw_o[usedw_off(c, AWIDTH) +: AWIDTH+1] = usedw_c[c];
        assign empty_o[c]        = flags_c[c].empty;
        assign almost_empty_o[c] = flags_c[c].almost_empty;
        assign full_o[c]         = flags_c[c].full;
        assign almost_full_o[c]  = flags_c[c].almost_full;
    end

    // At most one channel asserts each enable, so a priority-free select suffices.
    logic [AWIDTH-1:0] waddr_sel, raddr_sel;
    always_comb begin
        waddr_sel = '0;
        raddr_sel = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (we_c[c]) waddr_sel = waddr_c[c];
            if (re_c[c]) raddr_sel = raddr_c[c];
        end
    end

    // Request stage: pointers update here, RAM access happens one edge later.
    logic              s1_we_q, s1_re_q, s1_ovf_q, s1_udf_q;
    logic [RAW-1:0]    s1_waddr_q, s1_raddr_q;
    logic [DWIDTH-1:0] s1_wdata_q;
    logic [CHWIDTH-1:0] s1_ch_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_we_q    <= 1'b0;
            s1_re_q    <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_udf_q   <= 1'b0;
            s1_waddr_q <= '0;
            s1_raddr_q <= '0;
            s1_wdata_q <= '0;
            s1_ch_q    <= '0;
        end else begin
            s1_we_q    <= |we_c;
            s1_re_q    <= |re_c;
            s1_ovf_q   <= |ovf_c;
            s1_udf_q   <= |udf_c;
            s1_waddr_q <= {wrch_i, waddr_sel};
            s1_raddr_q <= {rdch_i, raddr_sel};
            s1_wdata_q <= data_i;
            s1_ch_q    <= rdch_i;
        end
    end

    // Write and read share one edge; the read sees the pre-write word, which is
    // what makes a same-channel swap return the old top.
    logic [DWIDTH-1:0] mem [CH_NUM*DEPTH];

    always_ff @(posedge clk_i) begin
        if (s1_we_q) mem[s1_waddr_q] <= s1_wdata_q;
    end

    logic [DWIDTH-1:0]  q_q;
    logic               q_valid_q, ovf_q, udf_q;
    logic [CHWIDTH-1:0] q_ch_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_ch_q    <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            q_valid_q <= s1_re_q;
            ovf_q     <= s1_ovf_q;
            udf_q     <= s1_udf_q;
            if (s1_re_q) begin
                q_q    <= mem[s1_raddr_q];
                q_ch_q <= s1_ch_q;
            end
        end
    end

    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
    assign q_ch_o    = q_ch_q;
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;

endmodule

// File: tb/tb_lifo_mc.sv
// tb_lifo_mc: directed + random stimulus against a per-channel stack model.
module tb_lifo_mc;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CH = 4;
    localparam int DEPTH = 256;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [CH-1:0] clr = '0;
    logic          wrreq = 1'b0;
    logic [1:0]    wrch = '0;
    logic [DW-1:0] data = '0;
    logic          rdreq = 1'b0;
    logic [1:0]    rdch = '0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [1:0]    q_ch;
    logic [CH-1:0] empty, aempty, full, afull;
    logic [CH*(AW+1)-1:0] usedw;
    logic          ovf, udf;

    lifo_mc #(
        .DWIDTH(DW), .AWIDTH(AW), .CH_NUM(CH),
        .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
    ) dut (
        .clk_i(clk), .arst_i(arst), .clr_i(clr),
        .wrreq_i(wrreq), .wrch_i(wrch), .data_i(data),
        .rdreq_i(rdreq), .rdch_i(rdch),
        .q_o(q), .q_valid_o(q_valid), .q_ch_o(q_ch),
        .empty_o(empty), .almost_empty_o(aempty), .full_o(full), .almost_full_o(afull),
        .usedw_o(usedw), .ovf_o(ovf), .udf_o(udf)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail = 0;

    // Model: plain arrays of stacks with sizes.
    logic [DW-1:0] mstk [CH][DEPTH];
    int            msz [CH];
    // Expected registered outputs (for the request of the previous step) and hold values.
    logic [DW-1:0] nq, pq;
    logic [1:0]    nch, pch;
    logic          pv, povf, pudf;
    int            cnt_v, cnt_ovf, cnt_udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) msz[c] = 0;
        nq = '0; pq = '0; nch = '0; pch = '0;
        pv = 1'b0; povf = 1'b0; pudf = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_usedw"}, 64'(usedw), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'hF);
        chk({tag, "_aempty"}, 64'(aempty), 64'hF);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_afull"}, 64'(afull), 64'd0);
        chk({tag, "_q"}, 64'(q), 64'd0);
        chk({tag, "_qv"}, 64'(q_valid), 64'd0);
        chk({tag, "_qch"}, 64'(q_ch), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_udf"}, 64'(udf), 64'd0);
    endtask

    // One clock: apply request, advance model, check outputs after the edge.
    task automatic step(input logic wr, input logic [1:0] wc, input logic [DW-1:0] d,
                        input logic rd, input logic [1:0] rc, input logic [CH-1:0] cl);
        logic wr_e, rd_e, cv, covf, cudf;
        logic [CH-1:0] e_exp, ae_exp, f_exp, af_exp;
        wrreq = wr; wrch = wc; data = d; rdreq = rd; rdch = rc; clr = cl;
        wr_e = wr && !cl[wc];
        rd_e = rd && !cl[rc];
        cv = 1'b0; covf = 1'b0; cudf = 1'b0;
        if (wr_e && rd_e && wc == rc) begin
            if (msz[wc] == 0) begin
                mstk[wc][0] = d; msz[wc] = 1; cudf = 1'b1;
            end else begin
                nq = mstk[wc][msz[wc]-1]; nch = rc; cv = 1'b1;
                mstk[wc][msz[wc]-1] = d;
            end
        end else begin
            if (rd_e) begin
                if (msz[rc] == 0) cudf = 1'b1;
                else begin
                    msz[rc]--; nq = mstk[rc][msz[rc]]; nch = rc; cv = 1'b1;
                end
            end
            if (wr_e) begin
                if (msz[wc] == DEPTH) covf = 1'b1;
                else begin
                    mstk[wc][msz[wc]] = d; msz[wc]++;
                end
            end
        end
        for (int c = 0; c < CH; c++) if (cl[c]) msz[c] = 0;

        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("usedw%0d", c), 64'(usedw[c*(AW+1) +: AW+1]), 64'(msz[c]));
            e_exp[c]  = (msz[c] == 0);
            ae_exp[c] = (msz[c] <= AE);
            f_exp[c]  = (msz[c] == DEPTH);
            af_exp[c] = (msz[c] >= AF);
        end
        chk("empty", 64'(empty), 64'(e_exp));
        chk("aempty", 64'(aempty), 64'(ae_exp));
        chk("full", 64'(full), 64'(f_exp));
        chk("afull", 64'(afull), 64'(af_exp));
        chk("q_valid", 64'(q_valid), 64'(pv));
        chk("q", 64'(q), 64'(pq));
        chk("q_ch", 64'(q_ch), 64'(pch));
        chk("ovf", 64'(ovf), 64'(povf));
        chk("udf", 64'(udf), 64'(pudf));
        if (q_valid) cnt_v++;
        if (ovf) cnt_ovf++;
        if (udf) cnt_udf++;
        pv = cv; povf = covf; pudf = cudf; pq = nq; pch = nch;
        wrreq = 1'b0; rdreq = 1'b0; clr = '0;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, '0, 1'b0, 2'd0, '0);
    endtask

    task automatic clr_counts();
        cnt_v = 0; cnt_ovf = 0; cnt_udf = 0;
    endtask

    initial begin
        model_reset();
        clr_counts();
        // Reset applied from time 0 and seen before any clock edge.
        #1;
        chk_reset("rst0");
        @(posedge clk); @(posedge clk); #1;
        arst = 1'b0;

        // Fill ch0 past full.
        clr_counts();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 2'd0, DW'($urandom), 1'b0, 2'd0, '0);
        idle();
        chk("fill_usedw0", 64'(usedw[AW:0]), 64'd256);
        chk("fill_full0", 64'(full[0]), 64'd1);
        chk("fill_ovf_cnt", 64'(cnt_ovf), 64'd1);
        chk("fill_others_empty", 64'(empty[3:1]), 64'h7);

        // Drain ch0 past empty.
        clr_counts();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd0, '0);
        idle();
        chk("drain_qv_cnt", 64'(cnt_v), 64'd256);
        chk("drain_udf_cnt", 64'(cnt_udf), 64'd1);
        chk("drain_empty0", 64'(empty[0]), 64'd1);

        // Interleaved pushes on ch1/ch2, then pop each.
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 2'd1 : 2'd2, DW'($urandom), 1'b0, 2'd0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd1, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
        idle();

        // Swap on ch3.
        step(1'b1, 2'd3, 16'h1111, 1'b0, 2'd0, '0);
        step(1'b1, 2'd3, 16'h2222, 1'b0, 2'd0, '0);
        step(1'b1, 2'd3, 16'h3333, 1'b0, 2'd0, '0);
        step(1'b1, 2'd3, 16'hBEEF, 1'b1, 2'd3, '0);
        idle();
        chk("swap_q", 64'(q), 64'h3333);
        chk("swap_usedw3", 64'(usedw[3*(AW+1) +: AW+1]), 64'd3);
        step(1'b0, 2'd0, '0, 1'b1, 2'd3, '0);
        idle();
        chk("swap_next_q", 64'(q), 64'hBEEF);

        // Same-channel push+pop on an empty channel, then clear with pop.
        step(1'b1, 2'd1, 16'h5A5A, 1'b1, 2'd1, '0);
        idle();
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, DW'($urandom), 1'b0, 2'd0, '0);
        clr_counts();
        step(1'b0, 2'd0, '0, 1'b1, 2'd0, 4'b0001);
        idle();
        chk("clr_usedw0", 64'(usedw[AW:0]), 64'd0);
        chk("clr_qv_cnt", 64'(cnt_v), 64'd0);
        chk("clr_udf_cnt", 64'(cnt_udf), 64'd0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic [CH-1:0] cl;
            cl = ($urandom_range(0, 49) == 0) ? CH'(1 << $urandom_range(0, 3)) : '0;
            step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), DW'($urandom),
                 $urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)), cl);
        end

        // Asynchronous reset during a pop burst.
        for (int i = 0; i < 8; i++) step(1'b1, 2'd2, DW'($urandom), 1'b0, 2'd0, '0);
        step(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
        step(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
        rdreq = 1'b1; rdch = 2'd2;
        #2 arst = 1'b1;
        #1;
        chk_reset("rst_mid");
        rdreq = 1'b0;
        @(posedge clk); #1;
        arst = 1'b0;
        model_reset();
        idle();
        step(1'b1, 2'd2, 16'hCAFE, 1'b0, 2'd0, '0);
        step(1'b0, 2'd0, '0, 1'b1, 2'd2, '0);
        idle();
        chk("post_rst_q", 64'(q), 64'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
